opb_register_bank_ppc2simulink: RTL and testbench

Parametrised bank of PPC-writable control registers on the OPB, driving Simulink user logic. Generalises the single software register to C_NUM_REGS registers of C_REG_WIDTH bits, with byte-enable writes and full readback. Optional shadow mode stages writes and applies them atomically on a software commit, with per-register update strobes. Single clock domain: user logic runs on OPB_Clk.

---
 rtl/opb_regbank_pkg.sv | 24 ++
 rtl/opb_regbank_slave_if.sv | 65 ++++++
 rtl/opb_register_bank_ppc2simulink.sv | 135 +++++++++++++
 tb/tb_opb_register_bank_ppc2simulink.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/opb_regbank_pkg.sv
// rtl/opb_regbank_pkg.sv - shared types, CTRL layout and byte-lane helper for the OPB register bank
package opb_regbank_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_e;

    // CTRL register layout in register bit numbering (bit 0 = OPB DBus[31])
    localparam int CTRL_COMMIT_BIT  = 0;
    localparam int CTRL_PENDING_BIT = 0;
    localparam int CTRL_COUNT_LSB   = 16;

    // OPB BE[0] (index 3 here) covers register bits 31:24, BE[3] (index 0) covers bits 7:0
    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        logic [31:0] mask;
        mask = '0;
        for (int j = 0; j < 4; j++) begin
            mask[j*8 +: 8] = {8{be[j]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/opb_regbank_slave_if.sv
// rtl/opb_regbank_slave_if.sv - OPB address decode, IDLE/ACK handshake FSM and Sl_* generation
module opb_regbank_slave_if
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR = 32'h0100_1100,
    parameter logic [31:0] C_HIGHADDR = 32'h0100_11FF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] abus_i,
    input  logic        select_i,
    input  logic        rnw_i,
    input  logic [31:0] rd_data_i,
    output logic        wr_en_o,
    output logic        rd_en_o,
    output logic [31:0] word_offset_o,
    output logic [31:0] sl_dbus_o,
    output logic        sl_xferack_o
);

    state_e      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dbus_q, dbus_d;
    logic        hit;

    assign hit           = select_i && (abus_i >= C_BASEADDR) && (abus_i <= C_HIGHADDR);
    assign word_offset_o = (abus_i - C_BASEADDR) >> 2;

    // Accept a transfer only from IDLE; ACK lasts exactly one cycle and ignores select
    always_comb begin
        state_d = state_q;
        wr_en_o = 1'b0;
        rd_en_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = ACK;
                    wr_en_o = !rnw_i;
                    rd_en_o = rnw_i;
                end
            end
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ack_d  = wr_en_o || rd_en_o;
        dbus_d = rd_en_o ? rd_data_i : '0;
    end

    // Handshake state plus registered ack/read data, so DBus is zero outside the ack cycle
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
            dbus_q  <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dbus_q  <= dbus_d;
        end
    end

    assign sl_xferack_o = ack_q;
    assign sl_dbus_o    = dbus_q;

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB control register bank with optional shadow/commit staging
module opb_register_bank_ppc2simulink
    import opb_regbank_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR    = 32'h0100_1100,
    parameter logic [31:0] C_HIGHADDR    = 32'h0100_11FF,
    parameter int          C_OPB_AWIDTH  = 32,
    parameter int          C_OPB_DWIDTH  = 32,
    parameter int          C_NUM_REGS    = 8,
    parameter int          C_REG_WIDTH   = 32,
    parameter logic [31:0] C_RESET_VALUE = 32'h0,
    parameter int          C_SHADOW_MODE = 1
) (
    input  logic                              OPB_Clk,
    input  logic                              OPB_Rst_n,
    // OPB bit 0 is the MSB; it sits at the top index of each vector here
    input  logic [C_OPB_AWIDTH-1:0]           OPB_ABus,
    input  logic [3:0]                        OPB_BE,
    input  logic [C_OPB_DWIDTH-1:0]           OPB_DBus,
    input  logic                              OPB_RNW,
    input  logic                              OPB_select,
    input  logic                              OPB_seqAddr,
    output logic [C_OPB_DWIDTH-1:0]           Sl_DBus,
    output logic                              Sl_xferAck,
    output logic                              Sl_errAck,
    output logic                              Sl_retry,
    output logic                              Sl_toutSup,
    output logic [C_NUM_REGS*C_REG_WIDTH-1:0] user_data_out,
    output logic [C_NUM_REGS-1:0]             user_data_valid
);

    localparam logic [C_REG_WIDTH-1:0] RST_V = C_RESET_VALUE[C_REG_WIDTH-1:0];
    localparam bit SHADOW = (C_SHADOW_MODE != 0);

    logic [C_REG_WIDTH-1:0] out_q    [C_NUM_REGS];
    logic [C_REG_WIDTH-1:0] shadow_q [C_NUM_REGS];
    logic [C_NUM_REGS-1:0]  dirty_q;
    logic [C_NUM_REGS-1:0]  valid_q;
    logic [15:0]            count_q;

    logic        wr_en, rd_en;
    logic [31:0] word_offset;
    logic [31:0] rd_data;
    logic [31:0] be_mask;
    logic        ctrl_sel;
    logic        commit_req;
    logic        unused_seqaddr;

    assign unused_seqaddr = OPB_seqAddr;
    assign be_mask        = be_to_mask(OPB_BE);
    assign ctrl_sel       = (word_offset == 32'(C_NUM_REGS));
    assign commit_req     = OPB_DBus[CTRL_COMMIT_BIT] && OPB_BE[0];

    opb_regbank_slave_if #(
        .C_BASEADDR (C_BASEADDR),
        .C_HIGHADDR (C_HIGHADDR)
    ) u_slave_if (
        .clk_i         (OPB_Clk),
        .rst_ni        (OPB_Rst_n),
        .abus_i        (32'(OPB_ABus)),
        .select_i      (OPB_select),
        .rnw_i         (OPB_RNW),
        .rd_data_i     (rd_data),
        .wr_en_o       (wr_en),
        .rd_en_o       (rd_en),
        .word_offset_o (word_offset),
        .sl_dbus_o     (Sl_DBus),
        .sl_xferack_o  (Sl_xferAck)
    );

    // Byte-enable merge of bus data into a register, dropping bits above the register width
    function automatic logic [C_REG_WIDTH-1:0] merge(input logic [C_REG_WIDTH-1:0] old);
        return C_REG_WIDTH'((32'(old) & ~be_mask) | (32'(OPB_DBus) & be_mask));
    endfunction

    // Register writes, commit copy, update strobes and commit counter
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                out_q[i]    <= RST_V;
                shadow_q[i] <= RST_V;
            end
            dirty_q <= '0;
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= '0;
            if (wr_en) begin
                for (int i = 0; i < C_NUM_REGS; i++) begin
                    if (word_offset == 32'(i)) begin
                        if (SHADOW) begin
                            shadow_q[i] <= merge(shadow_q[i]);
                            dirty_q[i]  <= 1'b1;
                        end else begin
                            out_q[i]    <= merge(out_q[i]);
                            valid_q[i]  <= 1'b1;
                        end
                    end
                end
                if (SHADOW && ctrl_sel && commit_req) begin
                    for (int i = 0; i < C_NUM_REGS; i++) begin
                        out_q[i] <= shadow_q[i];
                    end
                    valid_q <= dirty_q;
                    dirty_q <= '0;
                    count_q <= count_q + 16'd1;
                end
            end
        end
    end

    // Read mux: staged value in shadow mode, live output otherwise; CTRL carries count and pending
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < C_NUM_REGS; i++) begin
            if (word_offset == 32'(i)) begin
                rd_data = SHADOW ? 32'(shadow_q[i]) : 32'(out_q[i]);
            end
        end
        if (ctrl_sel) begin
            rd_data[CTRL_COUNT_LSB +: 16]  = count_q;
            rd_data[CTRL_PENDING_BIT]      = SHADOW && (|dirty_q);
        end
    end

    for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
        assign user_data_out[g*C_REG_WIDTH +: C_REG_WIDTH] = out_q[g];
    end

    assign user_data_valid = valid_q;
    assign Sl_errAck       = 1'b0;
    assign Sl_retry        = 1'b0;
    assign Sl_toutSup      = 1'b0;

endmodule

// File: tb/tb_opb_register_bank_ppc2simulink.sv
// tb/tb_opb_register_bank_ppc2simulink.sv - directed self-checking bench for shadow and direct register banks
module tb_opb_register_bank_ppc2simulink;

    localparam logic [31:0] BASE = 32'h0100_1100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] abus = '0;
    logic [3:0]  be = '0;
    logic [31:0] dbus = '0;
    logic        rnw = 1'b1;
    logic        sel1 = 1'b0;
    logic        sel0 = 1'b0;
    logic        seq = 1'b0;

    logic [31:0]  rd1, rd0;
    logic         ack1, ack0, err1, err0, rty1, rty0, tout1, tout0;
    logic [255:0] out1;
    logic [95:0]  out0;
    logic [7:0]   valid1, valid0;

    int checks = 0;
    int errors = 0;

    logic [31:0] x_rdata;
    logic        x_ack;
    logic [7:0]  x_valid1, x_valid0;

    always #5 clk = ~clk;

    opb_register_bank_ppc2simulink dut (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel1), .OPB_seqAddr(seq), .Sl_DBus(rd1), .Sl_xferAck(ack1),
        .Sl_errAck(err1), .Sl_retry(rty1), .Sl_toutSup(tout1), .user_data_out(out1),
        .user_data_valid(valid1)
    );

    opb_register_bank_ppc2simulink #(.C_REG_WIDTH(12), .C_SHADOW_MODE(0)) dut0 (
        .OPB_Clk(clk), .OPB_Rst_n(rst_n), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
        .OPB_RNW(rnw), .OPB_select(sel0), .OPB_seqAddr(seq), .Sl_DBus(rd0), .Sl_xferAck(ack0),
        .Sl_errAck(err0), .Sl_retry(rty0), .Sl_toutSup(tout0), .user_data_out(out0),
        .user_data_valid(valid0)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sel1 = 1'b0;
        sel0 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One transfer; captures what the addressed slave shows one edge after select
    task automatic xfer(input bit tgt0, input bit rd, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] ben);
        @(negedge clk);
        abus = addr; dbus = data; be = ben; rnw = rd;
        sel1 = !tgt0; sel0 = tgt0;
        @(posedge clk);
        #1;
        x_ack    = tgt0 ? ack0 : ack1;
        x_rdata  = tgt0 ? rd0 : rd1;
        x_valid1 = valid1;
        x_valid0 = valid0;
        @(negedge clk);
        sel1 = 1'b0; sel0 = 1'b0; rnw = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (ack1 !== 1'b0 || rd1 !== 32'h0) begin
            errors++; $display("FAIL reset_bus: ack=%b dbus=%h expected 0/0", ack1, rd1);
        end
        checks++;
        if (out1 !== 256'h0 || valid1 !== 8'h0 || err1 !== 1'b0 || rty1 !== 1'b0 || tout1 !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: out=%h valid=%h expected 0", out1, valid1);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1, BASE + 32'(i * 4), 32'h0, 4'h0);
            checks++;
            if (x_ack !== 1'b1 || x_rdata !== 32'h0 || x_valid1 !== 8'h0) begin
                errors++; $display("FAIL reset_reg%0d: ack=%b data=%h valid=%h expected 1/0/0", i, x_ack, x_rdata, x_valid1);
            end
        end
        xfer(0, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_ack !== 1'b1 || x_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_ctrl: ack=%b data=%h expected 1/0", x_ack, x_rdata);
        end
    endtask

    task automatic test_shadow_write();
        do_reset();
        xfer(0, 0, BASE + 32'h8, 32'hDEAD_BEEF, 4'hF);
        checks++;
        if (x_ack !== 1'b1 || x_valid1 !== 8'h0) begin
            errors++; $display("FAIL shadow_wr_ack: ack=%b valid=%h expected 1/00", x_ack, x_valid1);
        end
        xfer(0, 1, BASE + 32'h8, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL shadow_readback: got %h expected deadbeef", x_rdata);
        end
        checks++;
        if (out1[64 +: 32] !== 32'h0) begin
            errors++; $display("FAIL shadow_out_held: got %h expected 0", out1[64 +: 32]);
        end
        xfer(0, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h1) begin
            errors++; $display("FAIL shadow_pending: got %h expected 00000001", x_rdata);
        end
    endtask

    task automatic test_commit();
        do_reset();
        xfer(0, 0, BASE + 32'h4, 32'h11, 4'hF);
        xfer(0, 0, BASE + 32'h14, 32'h55, 4'hF);
        checks++;
        if (out1[32 +: 32] !== 32'h0 || out1[160 +: 32] !== 32'h0) begin
            errors++; $display("FAIL commit_pre: r1=%h r5=%h expected 0/0", out1[32 +: 32], out1[160 +: 32]);
        end
        xfer(0, 0, BASE + 32'h20, 32'h1, 4'hF);
        checks++;
        if (x_valid1 !== 8'h22) begin
            errors++; $display("FAIL commit_valid: got %h expected 22", x_valid1);
        end
        checks++;
        if (out1[32 +: 32] !== 32'h11 || out1[160 +: 32] !== 32'h55) begin
            errors++; $display("FAIL commit_out: r1=%h r5=%h expected 11/55", out1[32 +: 32], out1[160 +: 32]);
        end
        @(posedge clk); #1;
        checks++;
        if (valid1 !== 8'h0) begin
            errors++; $display("FAIL commit_valid_once: got %h expected 00", valid1);
        end
        xfer(0, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h0001_0000) begin
            errors++; $display("FAIL commit_ctrl: got %h expected 00010000", x_rdata);
        end
    endtask

    task automatic test_byte_enable();
        do_reset();
        xfer(0, 0, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
        xfer(0, 0, BASE + 32'hC, 32'h1234_5678, 4'b0100);
        xfer(0, 0, BASE + 32'h20, 32'h1, 4'h1);
        checks++;
        if (out1[96 +: 32] !== 32'hFF34_FFFF || x_valid1 !== 8'h08) begin
            errors++; $display("FAIL byte_enable_out: got %h valid %h expected ff34ffff/08", out1[96 +: 32], x_valid1);
        end
        xfer(0, 1, BASE + 32'hC, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'hFF34_FFFF) begin
            errors++; $display("FAIL byte_enable_rd: got %h expected ff34ffff", x_rdata);
        end
        // commit bit with its byte lane disabled must not commit
        xfer(0, 0, BASE + 32'h20, 32'h1, 4'hE);
        xfer(0, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h0001_0000) begin
            errors++; $display("FAIL commit_be_gated: got %h expected 00010000", x_rdata);
        end
    endtask

    task automatic test_unmapped();
        do_reset();
        xfer(0, 0, BASE + 32'h24, 32'hFFFF_FFFF, 4'hF);
        checks++;
        if (x_ack !== 1'b1 || x_valid1 !== 8'h0) begin
            errors++; $display("FAIL unmapped_wr: ack=%b valid=%h expected 1/00", x_ack, x_valid1);
        end
        xfer(0, 1, BASE + 32'h24, 32'h0, 4'h0);
        checks++;
        if (x_ack !== 1'b1 || x_rdata !== 32'h0) begin
            errors++; $display("FAIL unmapped_rd: ack=%b data=%h expected 1/0", x_ack, x_rdata);
        end
        xfer(0, 1, 32'h0100_1200, 32'h0, 4'h0);
        checks++;
        if (x_ack !== 1'b0) begin
            errors++; $display("FAIL out_of_range: ack=%b expected 0", x_ack);
        end
    endtask

    task automatic test_mode0();
        do_reset();
        xfer(1, 0, BASE, 32'h000A_BCDE, 4'hF);
        checks++;
        if (x_ack !== 1'b1 || x_valid0 !== 8'h01 || out0[11:0] !== 12'hCDE) begin
            errors++; $display("FAIL mode0_write: ack=%b valid=%h out=%h expected 1/01/cde", x_ack, x_valid0, out0[11:0]);
        end
        @(posedge clk); #1;
        checks++;
        if (valid0 !== 8'h0) begin
            errors++; $display("FAIL mode0_valid_once: got %h expected 00", valid0);
        end
        xfer(1, 1, BASE, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h0000_0CDE) begin
            errors++; $display("FAIL mode0_readback: got %h expected 00000cde", x_rdata);
        end
        xfer(1, 0, BASE + 32'h40, 32'h1234_5678, 4'hF);
        checks++;
        if (x_ack !== 1'b1) begin
            errors++; $display("FAIL mode0_unmapped_wr: ack=%b expected 1", x_ack);
        end
        xfer(1, 1, BASE + 32'h40, 32'h0, 4'h0);
        checks++;
        if (x_ack !== 1'b1 || x_rdata !== 32'h0) begin
            errors++; $display("FAIL mode0_unmapped_rd: ack=%b data=%h expected 1/0", x_ack, x_rdata);
        end
        xfer(1, 0, BASE + 32'h20, 32'h1, 4'hF);
        checks++;
        if (x_valid0 !== 8'h0) begin
            errors++; $display("FAIL mode0_ctrl_valid: got %h expected 00", x_valid0);
        end
        xfer(1, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h0 || out0 !== {84'h0, 12'hCDE}) begin
            errors++; $display("FAIL mode0_ctrl_ignored: ctrl=%h out=%h expected 0/cde", x_rdata, out0);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        abus = BASE; dbus = 32'hCAFE_F00D; be = 4'hF; rnw = 1'b0; sel1 = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack1 !== 1'b1) begin
            errors++; $display("FAIL midreset_ack_seen: got %b expected 1", ack1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack1 !== 1'b0 || rd1 !== 32'h0) begin
            errors++; $display("FAIL midreset_ack_drop: ack=%b dbus=%h expected 0/0", ack1, rd1);
        end
        @(negedge clk);
        sel1 = 1'b0; rnw = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(0, 1, BASE, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h0 || out1[31:0] !== 32'h0) begin
            errors++; $display("FAIL midreset_reg: rd=%h out=%h expected 0/0", x_rdata, out1[31:0]);
        end
    endtask

    task automatic test_commit_count();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            xfer(0, 0, BASE + 32'h20, 32'h1, 4'h1);
            checks++;
            if (x_valid1 !== 8'h0) begin
                errors++; $display("FAIL clean_commit_valid%0d: got %h expected 00", i, x_valid1);
            end
        end
        xfer(0, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h0003_0000) begin
            errors++; $display("FAIL commit_count3: got %h expected 00030000", x_rdata);
        end
        @(negedge clk);
        force dut.count_q = 16'hFFFF;
        #1;
        release dut.count_q;
        xfer(0, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'hFFFF_0000) begin
            errors++; $display("FAIL commit_count_preset: got %h expected ffff0000", x_rdata);
        end
        xfer(0, 0, BASE + 32'h20, 32'h1, 4'hF);
        xfer(0, 1, BASE + 32'h20, 32'h0, 4'h0);
        checks++;
        if (x_rdata !== 32'h0) begin
            errors++; $display("FAIL commit_count_wrap: got %h expected 00000000", x_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_shadow_write();
        test_commit();
        test_byte_enable();
        test_unmapped();
        test_mode0();
        test_reset_mid();
        test_commit_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
